bin_clause_mover: RTL

- Moves one bin of clauses between the clause-bin RAM and the clause array of a sat engine core.
- Load direction: RAM to core. Store direction: core to RAM, used for write-back of learnt or updated clauses.
- Parametrised successor of the fixed single-latency load path inside bin_manager. Adds a configurable RAM read latency, a store direction and a configurable bin depth.
- Sits between bin_manager's control FSM and the clause RAM / core carray ports.

---
 rtl/bin_clause_mover.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/bin_clause_mover.sv
// -----------------------------------------------------------------------------
// bin_clause_mover
//
// Moves one bin of NUM_CLAUSES_A_BIN clause rows between the clause-bin RAM
// and the clause array of a sat engine core.
//   load  (mode 0): RAM -> core, reads pipelined over RAM_RD_LATENCY cycles
//   store (mode 1): core -> RAM, write-back of learnt/updated clauses
// Row k of bin b lives at RAM address (b*NUM_CLAUSES_A_BIN + k) mod
// 2^ADDR_WIDTH_CLAUSES.
//
// Optional feature macro: BIN_CLAUSE_CHECKSUM_EN
//   adds checksum_o, the XOR of every row moved in the current operation.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start_i      request pulse, sampled only while busy_o = 0
//   mode_i       0 = load, 1 = store (sampled with start_i)
//   bin_id_i     bin to move (sampled with start_i)
//   busy_o       transfer in progress (includes the done_o cycle)
//   done_o       one-cycle completion pulse
//   ram_re_o     clause RAM read enable
//   ram_we_o     clause RAM write enable
//   ram_addr_o   clause RAM address
//   ram_din_o    clause RAM write data
//   ram_dout_i   clause RAM read data, valid RAM_RD_LATENCY cycles after read
//   wr_carray_o  one-hot core row write strobe
//   rd_carray_o  one-hot core row read select
//   clause_o     row data to core
//   clause_i     row data from core, combinational on rd_carray_o
//   checksum_o   (BIN_CLAUSE_CHECKSUM_EN only) XOR of transferred rows
// -----------------------------------------------------------------------------
module bin_clause_mover #(
   parameter int NUM_CLAUSES_A_BIN  = 8,
   parameter int NUM_VARS_A_BIN     = 8,
   parameter int WIDTH_CLAUSES      = NUM_VARS_A_BIN * 2,
   parameter int WIDTH_BIN_ID       = 10,
   parameter int ADDR_WIDTH_CLAUSES = 9,
   parameter int RAM_RD_LATENCY     = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          start_i,
   input  logic                          mode_i,
   input  logic [WIDTH_BIN_ID-1:0]       bin_id_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          ram_re_o,
   output logic                          ram_we_o,
   output logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_o,
   output logic [WIDTH_CLAUSES-1:0]      ram_din_o,
   input  logic [WIDTH_CLAUSES-1:0]      ram_dout_i,
   output logic [NUM_CLAUSES_A_BIN-1:0]  wr_carray_o,
   output logic [NUM_CLAUSES_A_BIN-1:0]  rd_carray_o,
   output logic [WIDTH_CLAUSES-1:0]      clause_o,
   input  logic [WIDTH_CLAUSES-1:0]      clause_i
`ifdef BIN_CLAUSE_CHECKSUM_EN
   ,
   output logic [WIDTH_CLAUSES-1:0]      checksum_o
`endif
);

   localparam int N  = NUM_CLAUSES_A_BIN;
   localparam int L  = RAM_RD_LATENCY;
   localparam int AW = ADDR_WIDTH_CLAUSES;
   localparam int CW = $clog2(N + 1);          // counts 0..N
   localparam int IW = (N > 1) ? $clog2(N) : 1; // row index 0..N-1

   // Every pipe stage except the exiting one; used to detect "drained".
   localparam logic [L-1:0] NONEXIT_MASK = {L{1'b1}} >> 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_ISSUE,
      LOAD_DRAIN,
      STORE,
      DONE
   } state_t;

   state_t                  state, state_nx;
   logic [CW-1:0]           cnt;
   logic [WIDTH_BIN_ID-1:0] bin_q;

   // Load read pipe: one (valid, row index) entry per outstanding read.
   logic [L-1:0]            pipe_v;
   logic [IW-1:0]           pipe_k [L];

   // Store stage: row captured from the core, written to RAM next cycle.
   logic                    st_v;
   logic [IW-1:0]           st_k;
   logic [WIDTH_CLAUSES-1:0] st_data;

   logic                    start_ok;
   logic                    issue;
   logic                    capture;
   logic                    exit_v;
   logic [IW-1:0]           exit_k;
   logic [IW-1:0]           k_cur;
   logic [AW-1:0]           base;
   logic [AW-1:0]           rd_addr;
   logic [AW-1:0]           wr_addr;

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] k);
      logic [N-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i] = (k == IW'(i));
      return r;
   endfunction

   assign start_ok = (state == IDLE) && start_i;
   assign issue    = (state == LOAD_ISSUE);
   assign capture  = (state == STORE) && (cnt < CW'(N));
   assign k_cur    = IW'(cnt);
   assign exit_v   = pipe_v[L-1];
   assign exit_k   = pipe_k[L-1];

   // Truncation to AW bits gives the modulo-2^AW wrap of the bin base.
   assign base    = AW'(bin_q * N);
   assign rd_addr = base + AW'(k_cur);
   assign wr_addr = base + AW'(st_k);

   // -------------------------------------------------------------------------
   // State register and datapath registers
   // -------------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so every register
   // samples the values of the previous cycle regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bin_q   <= '0;
         pipe_v  <= '0;
         for (int i = 0; i < L; i++) pipe_k[i] <= '0;
         st_v    <= 1'b0;
         st_k    <= '0;
         st_data <= '0;
      end else begin
         state <= state_nx;

         if (start_ok) begin
            bin_q <= bin_id_i;
            cnt   <= '0;
         end else if (issue || capture) begin
            cnt <= cnt + 1'b1;
         end

         pipe_v[0] <= issue;
         pipe_k[0] <= k_cur;
         for (int i = 1; i < L; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_k[i] <= pipe_k[i-1];
         end

         st_v <= capture;
         if (capture) begin
            st_k    <= k_cur;
            st_data <= clause_i;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next state and outputs
   // -------------------------------------------------------------------------
   // NOTE: every signal gets a default at the top of the block so no path
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nx    = state;
      busy_o      = (state != IDLE);
      done_o      = (state == DONE);
      ram_re_o    = issue;
      ram_we_o    = st_v;
      ram_addr_o  = '0;
      ram_din_o   = '0;
      wr_carray_o = '0;
      rd_carray_o = '0;
      clause_o    = '0;

      if (issue)     ram_addr_o = rd_addr;
      else if (st_v) ram_addr_o = wr_addr;

      if (st_v)    ram_din_o   = st_data;
      if (capture) rd_carray_o = onehot(k_cur);

      // Read data returns independently of the state: a row is written to
      // the core exactly when its read leaves the latency pipe.
      if (exit_v) begin
         wr_carray_o = onehot(exit_k);
         clause_o    = ram_dout_i;
      end

      case (state)
         IDLE:       if (start_i) state_nx = mode_i ? STORE : LOAD_ISSUE;
         LOAD_ISSUE: if (cnt == CW'(N - 1)) state_nx = LOAD_DRAIN;
         // The exiting entry is written this cycle, so DONE may follow once
         // no other stage still holds a read.
         LOAD_DRAIN: if ((pipe_v & NONEXIT_MASK) == '0) state_nx = DONE;
         STORE:      if (st_v && (st_k == IW'(N - 1))) state_nx = DONE;
         DONE:       state_nx = IDLE;
         default:    state_nx = IDLE;
      endcase
   end

`ifdef BIN_CLAUSE_CHECKSUM_EN
   // Accumulates over the operation; nothing moves after done_o, so the value
   // stays put until the next accepted start clears it.
   logic [WIDTH_CLAUSES-1:0] csum;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          csum <= '0;
      else if (start_ok) csum <= '0;
      else if (exit_v)   csum <= csum ^ ram_dout_i;
      else if (capture)  csum <= csum ^ clause_i;
   end

   assign checksum_o = csum;
`else
   // Checksum accumulator not built.
`endif

endmodule
